traffic_phase_ctrl: RTL and testbench
=====================================

Name: traffic_phase_ctrl

Overview:
Parametrised N-direction intersection controller, successor to the fixed 4-way controller. It adds:
- full red/yellow/green per direction
- sticky demand requests with round-robin skip of idle directions
- rest-in-green when no other direction has demand
- an all-red clearance interval
- a flashing-yellow fault/night mode
It sits behind the top-level pin wrapper, which maps its light vectors to pins.

Parameters:
NUM_DIR, 4, number of approach directions (2..8)
TICK_DIV, 10_000_000, clk cycles per timing tick (>=2)
GREEN_TICKS, 30, green duration in ticks (>=1)
YELLOW_TICKS, 3, yellow duration in ticks (>=1)
ALLRED_TICKS, 1, all-red clearance in ticks (>=1)
CNT_W, 8, phase timer width; every *_TICKS value must fit

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_i  in  NUM_DIR  per-direction demand (level or pulse)
flash_mode_i  in  1  request flashing-yellow mode
red_o  out  NUM_DIR  red lamp per direction
yellow_o  out  NUM_DIR  yellow lamp per direction
green_o  out  NUM_DIR  green lamp per direction
active_dir_o  out  $clog2(NUM_DIR)  direction currently owning the phase
phase_o  out  2  0=ALL_RED, 1=GREEN, 2=YELLOW, 3=FLASH
served_o  out  1  1-cycle pulse on each GREEN entry

Behaviour:
- Reset (sampled on clk edge, priority over all else):
  - state ALL_RED, timer=ALLRED_TICKS, prescaler=0, active_dir=0, req_latch=0, flash_toggle=0, served_o=0.
  - Outputs: red_o all 1, yellow_o/green_o all 0.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for the one cycle at TICK_DIV-1. The first tick after reset comes TICK_DIV cycles after reset release.
- Phase timer: loaded on phase entry, decremented on tick. The phase ends on the tick that takes the timer 1->0, so a phase lasts exactly its *_TICKS ticks. The transition takes effect the next clk edge.
- req_latch: req_i is ORed in every cycle. The active direction's bit is cleared on GREEN entry. If req_i for that bit is high in the same cycle, set wins and the bit stays 1.
- ALL_RED: all red. On expiry:
  - flash_mode_i=1 -> FLASH.
  - Else pick the next direction: first set req_latch bit scanning active_dir+1, +2, ..., active_dir (cyclic, wrap NUM_DIR-1 -> 0, non-power-of-2 safe).
  - If no bit is set, take active_dir+1 mod NUM_DIR (free rotation).
  - Then -> GREEN, timer=GREEN_TICKS, served_o=1 for that cycle.
- GREEN: green_o[active]=1; all other directions red.
  - On expiry with no pending request in any other direction: stay GREEN and reload GREEN_TICKS (no served_o pulse).
  - On expiry otherwise -> YELLOW, timer=YELLOW_TICKS.
  - flash_mode_i=1 at any cycle forces YELLOW on the next edge (timer reload).
- YELLOW: yellow_o[active]=1; all other directions red. On expiry -> ALL_RED, timer=ALLRED_TICKS. flash_mode_i does not shorten yellow.
- FLASH: red_o=0, green_o=0, yellow_o = all flash_toggle. flash_toggle inverts on every tick.
  - On the cycle flash_mode_i=0 is seen: -> ALL_RED, timer=ALLRED_TICKS, flash_toggle=0. active_dir is unchanged.
- Invariants:
  - At most one green_o bit set, and it never shares a cycle with any yellow.
  - Each direction has exactly one lamp lit, except in FLASH.
  - GREEN is always preceded by ALL_RED.
- Outputs are registered or decoded purely from registered state; no combinational path from req_i to lamps.

Decomposition:
- traffic_pkg:
  - phase encoding constants (PH_ALL_RED, PH_GREEN, PH_YELLOW, PH_FLASH)
  - state typedef
  - DIR_W = $clog2(NUM_DIR) helper function
- Sub-module traffic_rr_pick: combinational cyclic priority search. Inputs: req vector, start index. Outputs: found flag, index. Shared by this block and future pedestrian-phase blocks.
- Prescaler and FSM stay inline.

Test Plan:
All scenarios use NUM_DIR=4, TICK_DIV=2, GREEN_TICKS=3, YELLOW_TICKS=2, ALLRED_TICKS=1.
- Reset then req_i=0 -> ALL_RED for 2 cycles, then GREEN dir1 for 6 cycles and rests (no other demand): green_o=0010 stays, red_o=1101.
- From rest in dir1, pulse req_i=1000 for one cycle -> at green expiry: YELLOW 4 cycles, ALL_RED 2 cycles, GREEN dir3, served_o one pulse, req_latch[3] cleared.
- req_i=0101 held from reset -> sequence dir2, dir0, dir2, dir0. Dirs 1 and 3 never green; directions are skipped in zero extra cycles.
- NUM_DIR=3 build, req_i=0 -> rotation 1,2,0,1; active_dir_o never equals 3.
- flash_mode_i=1 mid-GREEN dir0 -> next edge YELLOW (yellow_o=0001), then ALL_RED, then FLASH with yellow_o toggling 1111/0000 every 2 cycles. Release -> ALL_RED 2 cycles, then GREEN.
- reset asserted mid-YELLOW for one cycle -> next edge all red, phase_o=0, active_dir_o=0, req_latch cleared. Check the invariant assertions every cycle.

Source files
------------

// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared phase encodings and sizing helpers for the intersection
//               controller family.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_ALL_RED = 2'd0;
  localparam phase_t PH_GREEN   = 2'd1;
  localparam phase_t PH_YELLOW  = 2'd2;
  localparam phase_t PH_FLASH   = 2'd3;

  // Index width for a direction count; never narrower than one bit.
  function automatic int dir_w(input int n);
    if (n < 2) return 1;
    return $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : traffic_rr_pick
// Description : Combinational cyclic priority search: first set request bit
//               at or after start_i, wrapping N-1 -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
import traffic_pkg::*;

module traffic_rr_pick #(
  parameter int N = 4,
  parameter int W = dir_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W:0] w_cand;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    w_cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = {1'b0, start_i} + (W+1)'(k);
      if (w_cand >= (W+1)'(N)) w_cand = w_cand - (W+1)'(N);
      if (req_i[w_cand[W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = w_cand[W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_ctrl
// Description : N-direction intersection controller with sticky demand,
//               round-robin skip, rest-in-green, all-red clearance and flash.
// Revision    : 1.0 - initial release
// ============================================================================
import traffic_pkg::*;

module traffic_phase_ctrl #(
  parameter int NUM_DIR      = 4,
  parameter int TICK_DIV     = 10_000_000,
  parameter int GREEN_TICKS  = 30,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int CNT_W        = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_DIR-1:0]          req_i,
  input  logic                        flash_mode_i,
  output logic [NUM_DIR-1:0]          red_o,
  output logic [NUM_DIR-1:0]          yellow_o,
  output logic [NUM_DIR-1:0]          green_o,
  output logic [dir_w(NUM_DIR)-1:0]   active_dir_o,
  output logic [1:0]                  phase_o,
  output logic                        served_o
);

  localparam int DIR_W = dir_w(NUM_DIR);
  localparam int PS_W  = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

  localparam logic [PS_W-1:0]  C_PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] C_GREEN   = CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0] C_YELLOW  = CNT_W'(YELLOW_TICKS);
  localparam logic [CNT_W-1:0] C_ALLRED  = CNT_W'(ALLRED_TICKS);
  localparam logic [DIR_W-1:0] C_LAST_DIR = DIR_W'(NUM_DIR - 1);

  phase_t             r_state;
  logic [PS_W-1:0]    r_presc;
  logic [CNT_W-1:0]   r_timer;
  logic [DIR_W-1:0]   r_active;
  logic [NUM_DIR-1:0] r_req_latch;
  logic               r_flash_toggle;
  logic               r_served;

  logic               w_tick;
  logic               w_expire;
  logic [DIR_W-1:0]   w_start;
  logic               w_found;
  logic [DIR_W-1:0]   w_found_idx;
  logic [DIR_W-1:0]   w_pick;
  logic [NUM_DIR-1:0] w_active_oh;
  logic [NUM_DIR-1:0] w_pick_oh;
  logic               w_others_pending;

  assign w_tick   = (r_presc == C_PS_LAST);
  assign w_expire = w_tick && (r_timer == CNT_W'(1));

  assign w_start = (r_active == C_LAST_DIR) ? '0 : r_active + 1'b1;

  traffic_rr_pick #(
    .N (NUM_DIR),
    .W (DIR_W)
  ) u_rr_pick (
    .req_i   (r_req_latch),
    .start_i (w_start),
    .found_o (w_found),
    .idx_o   (w_found_idx)
  );

  // No pending demand means free rotation to the next direction.
  assign w_pick           = w_found ? w_found_idx : w_start;
  assign w_active_oh      = NUM_DIR'(1) << r_active;
  assign w_pick_oh        = NUM_DIR'(1) << w_pick;
  assign w_others_pending = |(r_req_latch & ~w_active_oh);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= PH_ALL_RED;
      r_presc        <= '0;
      r_timer        <= C_ALLRED;
      r_active       <= '0;
      r_req_latch    <= '0;
      r_flash_toggle <= 1'b0;
      r_served       <= 1'b0;
    end else begin
      r_presc     <= w_tick ? '0 : r_presc + 1'b1;
      r_served    <= 1'b0;
      r_req_latch <= r_req_latch | req_i;
      if (w_tick && (r_timer != '0)) r_timer <= r_timer - 1'b1;

      case (r_state)
        PH_ALL_RED: begin
          if (w_expire) begin
            if (flash_mode_i) begin
              r_state <= PH_FLASH;
            end else begin
              r_state     <= PH_GREEN;
              r_active    <= w_pick;
              r_timer     <= C_GREEN;
              r_served    <= 1'b1;
              // A same-cycle request for the new owner survives the clear.
              r_req_latch <= (r_req_latch & ~w_pick_oh) | req_i;
            end
          end
        end
        PH_GREEN: begin
          if (flash_mode_i || (w_expire && w_others_pending)) begin
            r_state <= PH_YELLOW;
            r_timer <= C_YELLOW;
          end else if (w_expire) begin
            r_timer <= C_GREEN;
          end
        end
        PH_YELLOW: begin
          if (w_expire) begin
            r_state <= PH_ALL_RED;
            r_timer <= C_ALLRED;
          end
        end
        PH_FLASH: begin
          if (!flash_mode_i) begin
            r_state        <= PH_ALL_RED;
            r_timer        <= C_ALLRED;
            r_flash_toggle <= 1'b0;
          end else if (w_tick) begin
            r_flash_toggle <= ~r_flash_toggle;
          end
        end
        default: r_state <= PH_ALL_RED;
      endcase
    end
  end

  assign red_o    = (r_state == PH_ALL_RED) ? '1 :
                    (r_state == PH_FLASH)   ? '0 : ~w_active_oh;
  assign yellow_o = (r_state == PH_YELLOW)  ? w_active_oh :
                    (r_state == PH_FLASH)   ? {NUM_DIR{r_flash_toggle}} : '0;
  assign green_o  = (r_state == PH_GREEN)   ? w_active_oh : '0;

  assign active_dir_o = r_active;
  assign phase_o      = r_state;
  assign served_o     = r_served;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_ctrl
// Description : Directed self-checking bench for traffic_phase_ctrl (4-way and
//               3-way builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = '0;
  logic       flash = 1'b0;
  logic [3:0] red, yellow, green;
  logic [1:0] active, phase;
  logic       served;

  logic [2:0] req3 = '0;
  logic       flash3 = 1'b0;
  logic [2:0] red3, yellow3, green3;
  logic [1:0] active3, phase3;
  logic       served3;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [16:0] obs, exp_v;

  always #5 clk = ~clk;

  traffic_phase_ctrl #(
    .NUM_DIR(4), .TICK_DIV(2), .GREEN_TICKS(3), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req), .flash_mode_i(flash),
    .red_o(red), .yellow_o(yellow), .green_o(green),
    .active_dir_o(active), .phase_o(phase), .served_o(served)
  );

  traffic_phase_ctrl #(
    .NUM_DIR(3), .TICK_DIV(2), .GREEN_TICKS(3), .YELLOW_TICKS(2), .ALLRED_TICKS(1), .CNT_W(8)
  ) dut3 (
    .clk(clk), .reset(reset), .req_i(req3), .flash_mode_i(flash3),
    .red_o(red3), .yellow_o(yellow3), .green_o(green3),
    .active_dir_o(active3), .phase_o(phase3), .served_o(served3)
  );

  // Observation packing: {phase, active, red, yellow, green, served}
  assign obs = {phase, active, red, yellow, green, served};

  // Lamp invariants, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ($countones(green) > 1 || (|green && |yellow)) begin
        bad++;
        $display("FAIL inv_green t=%0t: green=%b yellow=%b", $time, green, yellow);
      end
      total++;
      if (phase != 2'd3 && ((red | yellow | green) != 4'b1111 ||
          (red & yellow) != 0 || (red & green) != 0 || (yellow & green) != 0)) begin
        bad++;
        $display("FAIL inv_one_lamp t=%0t: red=%b yellow=%b green=%b", $time, red, yellow, green);
      end
      total++;
      if (active3 > 2'd2 || $countones(green3) > 1) begin
        bad++;
        $display("FAIL inv_dut3 t=%0t: active=%0d green=%b want active<=2", $time, active3, green3);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; flash = 1'b0; req3 = '0; flash3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk_en = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c < 2) exp_v = {2'd0, 2'd0, 4'b1111, 4'b0000, 4'b0000, 1'b0};
      else       exp_v = {2'd1, 2'd1, 4'b1101, 4'b0000, 4'b0010, 1'(c == 2)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL test_reset c=%0d: got %b want %b", c, obs, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_demand_pulse();
    do_reset();
    for (int c = 0; c < 24; c++) begin
      if (c < 2)       exp_v = {2'd0, 2'd0, 4'b1111, 4'b0000, 4'b0000, 1'b0};
      else if (c < 14) exp_v = {2'd1, 2'd1, 4'b1101, 4'b0000, 4'b0010, 1'(c == 2)};
      else if (c < 18) exp_v = {2'd2, 2'd1, 4'b1101, 4'b0010, 4'b0000, 1'b0};
      else if (c < 20) exp_v = {2'd0, 2'd1, 4'b1111, 4'b0000, 4'b0000, 1'b0};
      else             exp_v = {2'd1, 2'd3, 4'b0111, 4'b0000, 4'b1000, 1'(c == 20)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL test_demand_pulse c=%0d: got %b want %b", c, obs, exp_v);
      end
      if (c == 21) begin
        total++;
        if (dut.r_req_latch !== 4'b0000) begin
          bad++;
          $display("FAIL test_demand_latch_clear: got %b want 0000", dut.r_req_latch);
        end
      end
      if (c == 10) req = 4'b1000;
      if (c == 11) req = 4'b0000;
      next_cycle();
    end
  endtask

  task automatic test_skip_idle();
    logic [1:0] d;
    logic [3:0] oh;
    int o;
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < 44; c++) begin
      if (c < 2) begin
        exp_v = {2'd0, 2'd0, 4'b1111, 4'b0000, 4'b0000, 1'b0};
      end else begin
        o  = (c - 2) % 12;
        d  = (((c - 2) / 12) % 2 == 0) ? 2'd2 : 2'd0;
        oh = (d == 2'd2) ? 4'b0100 : 4'b0001;
        if (o < 6)       exp_v = {2'd1, d, ~oh, 4'b0000, oh, 1'(o == 0)};
        else if (o < 10) exp_v = {2'd2, d, ~oh, oh, 4'b0000, 1'b0};
        else             exp_v = {2'd0, d, 4'b1111, 4'b0000, 4'b0000, 1'b0};
      end
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL test_skip_idle c=%0d: got %b want %b", c, obs, exp_v);
      end
      next_cycle();
    end
    req = '0;
  endtask

  task automatic test_three_dir();
    logic [1:0] exp_dir [4];
    exp_dir = '{2'd1, 2'd2, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      for (int w = 0; w < 40 && !served3; w++) next_cycle();
      total++;
      if (!served3) begin
        bad++;
        $display("FAIL test_three_dir_timeout i=%0d: served=%b want 1", i, served3);
      end else if (active3 !== exp_dir[i] || green3 !== (3'b001 << exp_dir[i])) begin
        bad++;
        $display("FAIL test_three_dir i=%0d: got dir=%0d green=%b want dir=%0d", i, active3, green3, exp_dir[i]);
      end
      flash3 = 1'b1;
      next_cycle();
      flash3 = 1'b0;
    end
  endtask

  task automatic test_flash();
    do_reset();
    for (int c = 0; c < 22; c++) begin
      if (c < 2)       exp_v = {2'd0, 2'd0, 4'b1111, 4'b0000, 4'b0000, 1'b0};
      else if (c < 4)  exp_v = {2'd1, 2'd0, 4'b1110, 4'b0000, 4'b0001, 1'(c == 2)};
      else if (c < 8)  exp_v = {2'd2, 2'd0, 4'b1110, 4'b0001, 4'b0000, 1'b0};
      else if (c < 10) exp_v = {2'd0, 2'd0, 4'b1111, 4'b0000, 4'b0000, 1'b0};
      else if (c < 18) exp_v = {2'd3, 2'd0, 4'b0000, (((c - 10) / 2) % 2 == 1) ? 4'b1111 : 4'b0000, 4'b0000, 1'b0};
      else if (c < 20) exp_v = {2'd0, 2'd0, 4'b1111, 4'b0000, 4'b0000, 1'b0};
      else             exp_v = {2'd1, 2'd1, 4'b1101, 4'b0000, 4'b0010, 1'(c == 20)};
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL test_flash c=%0d: got %b want %b", c, obs, exp_v);
      end
      if (c == 0)  req = 4'b0001;
      if (c == 1)  req = 4'b0000;
      if (c == 3)  flash = 1'b1;
      if (c == 17) flash = 1'b0;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_yellow();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c >= 8) begin
        if (c < 10)      exp_v = {2'd2, 2'd1, 4'b1101, 4'b0010, 4'b0000, 1'b0};
        else if (c < 12) exp_v = {2'd0, 2'd0, 4'b1111, 4'b0000, 4'b0000, 1'b0};
        else             exp_v = {2'd1, 2'd1, 4'b1101, 4'b0000, 4'b0010, 1'(c == 12)};
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL test_reset_mid_yellow c=%0d: got %b want %b", c, obs, exp_v);
        end
      end
      if (c == 3)  req = 4'b0100;
      if (c == 4)  req = 4'b0000;
      if (c == 9)  reset = 1'b1;
      if (c == 10) reset = 1'b0;
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_demand_pulse();
    test_skip_idle();
    test_three_dir();
    test_flash();
    test_reset_mid_yellow();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
